// File: rtl/jtdsp16_prog_loader_if.sv
// Byte-stream download and program-ROM write bus of the DSP16 program loader.
// The master side is the system (byte source, ROM observer); the slave side
// is the loader itself.
interface jtdsp16_prog_loader_if #(
  parameter int AW = 12
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          prog_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, prog_addr, prog_data, prog_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, prog_addr, prog_data, prog_we
  );
endinterface

// File: rtl/jtdsp16_prog_loader.sv
// DSP16 program loader: assembles little-endian 16-bit words from a byte
// stream, writes them to program ROM addresses 0..LEN-1 and holds the DSP
// core in reset until the image is complete.
// Optional feature: define JTDSP16_PROG_CHKSUM_EN to append a two-byte
// checksum trailer (16-bit sum of all words); a mismatch sets err and keeps
// the DSP in reset.
module jtdsp16_prog_loader #(
  parameter int AW  = 12,
  parameter int LEN = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  jtdsp16_prog_loader_if.slave bus,
  output logic                 dsp_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
    DONE
`ifdef JTDSP16_PROG_CHKSUM_EN
    ,
    CKLO,
    CKHI
`endif
  } state_t;

  state_t        state;
  logic          in_ready;
  logic          accept;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          prog_we;

`ifdef JTDSP16_PROG_CHKSUM_EN
  logic [15:0] sum;
  logic [7:0]  ck_lo;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.prog_addr = prog_addr;
  assign bus.prog_data = prog_data;
  assign bus.prog_we   = prog_we;
  assign accept        = bus.in_valid & in_ready;

  // Byte acceptance is a pure decode of the registered state.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    case (state)
      LO, HI: in_ready = 1'b1;
`ifdef JTDSP16_PROG_CHKSUM_EN
      CKLO, CKHI: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

`ifndef JTDSP16_PROG_CHKSUM_EN
  assign err = 1'b0;
`endif

  // Load sequencer: byte assembly, ROM write strobe and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef JTDSP16_PROG_CHKSUM_EN
      err       <= 1'b0;
      sum       <= '0;
      ck_lo     <= '0;
`endif
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge values.
      prog_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LO;
            prog_addr <= '0;
            done      <= 1'b0;
            dsp_rst   <= 1'b1;
            busy      <= 1'b1;
`ifdef JTDSP16_PROG_CHKSUM_EN
            err       <= 1'b0;
            sum       <= '0;
`endif
          end
        end
        LO: begin
          if (accept) begin
            prog_data[7:0] <= bus.in_data;
            state          <= HI;
          end
        end
        HI: begin
          if (accept) begin
            prog_data[15:8] <= bus.in_data;
            prog_we         <= 1'b1;
            state           <= WR;
          end
        end
        WR: begin
`ifdef JTDSP16_PROG_CHKSUM_EN
          sum <= sum + prog_data;
`endif
          if (prog_addr != LAST) begin
            prog_addr <= prog_addr + AW'(1);
            state     <= LO;
          end else begin
`ifdef JTDSP16_PROG_CHKSUM_EN
            state <= CKLO;
`else
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dsp_rst <= 1'b0;
`endif
          end
        end
`ifdef JTDSP16_PROG_CHKSUM_EN
        CKLO: begin
          if (accept) begin
            ck_lo <= bus.in_data;
            state <= CKHI;
          end
        end
        CKHI: begin
          if (accept) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= ({bus.in_data, ck_lo} != sum);
            dsp_rst <= ({bus.in_data, ck_lo} != sum);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// Self-checking bench for jtdsp16_prog_loader. Two instances share the byte
// stream: A (AW=2, LEN=4, image fills the whole address space) and
// B (AW=4, LEN=5). Only the selected instance receives start pulses.
module tb_jtdsp16_prog_loader;

  localparam int AWA = 2, LENA = 4;
  localparam int AWB = 4, LENB = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] in_data;
  logic       in_valid;

  always #5 clk = ~clk;

  jtdsp16_prog_loader_if #(.AW(AWA)) ifa ();
  jtdsp16_prog_loader_if #(.AW(AWB)) ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;

  logic start_a, start_b;
  logic dsp_rst_a, busy_a, done_a, err_a;
  logic dsp_rst_b, busy_b, done_b, err_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  jtdsp16_prog_loader #(.AW(AWA), .LEN(LENA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
    .dsp_rst(dsp_rst_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  jtdsp16_prog_loader #(.AW(AWB), .LEN(LENB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
    .dsp_rst(dsp_rst_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Observed view of the selected instance.
  logic [3:0]  o_addr;
  logic [15:0] o_data;
  logic        o_we, o_ready, o_dsp_rst, o_busy, o_done, o_err;

  always_comb begin
    if (sel) begin
      o_addr = ifb.prog_addr;         o_data = ifb.prog_data;
      o_we = ifb.prog_we;             o_ready = ifb.in_ready;
      o_dsp_rst = dsp_rst_b;          o_busy = busy_b;
      o_done = done_b;                o_err = err_b;
    end else begin
      o_addr = {2'b00, ifa.prog_addr}; o_data = ifa.prog_data;
      o_we = ifa.prog_we;             o_ready = ifa.in_ready;
      o_dsp_rst = dsp_rst_a;          o_busy = busy_a;
      o_done = done_a;                o_err = err_a;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Cycle counter and write/done monitor.
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   done_rises = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_we) wq.push_back('{int'(o_addr), int'(o_data), cyc});
    if (o_done && !done_q) done_rises <= done_rises + 1;
    done_q <= o_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after an optional idle gap; returns once it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (gap > 0 && t == 0) check("gap_ready", o_ready, 1);
      if (o_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // One complete load against the reference model: expected writes are
  // word i = {byte[2i+1], byte[2i]} at address i, in order.
  task automatic run_load(input bit s, input logic [7:0] bytes[$], input int gap_hi,
                          input bit rand_gaps, input bit poke, input bit start_with_valid,
                          input bit bad_ck);
    logic [15:0] words[$];
    logic [15:0] total;
    logic [15:0] trailer;
    int          n, base_w, base_d, gap;
    bit          exp_err, no_gaps, got_done;

    n     = bytes.size() / 2;
    total = '0;
    for (int i = 0; i < n; i++) begin
      words.push_back({bytes[2*i+1], bytes[2*i]});
      total = total + {bytes[2*i+1], bytes[2*i]};
    end
`ifdef JTDSP16_PROG_CHKSUM_EN
    exp_err = bad_ck;
`else
    exp_err = 1'b0;
`endif
    no_gaps = (gap_hi == 0) && !rand_gaps && !poke;

    in_valid = 1'b0;
    sel      = s;
    tick();
    start = 1'b1;
    if (start_with_valid) begin
      in_valid = 1'b1;
      in_data  = bytes[0];
    end
    tick();
    start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_dsp_rst", o_dsp_rst, 1);
    check("start_done", o_done, 0);
    check("start_addr", o_addr, 0);
    check("start_err", o_err, 0);
    check("start_ready", o_ready, 1);
    base_w = wq.size();
    base_d = done_rises;

    for (int i = 0; i < 2 * n; i++) begin
      gap = 0;
      if (i % 2 == 1) gap = gap_hi;
      if (rand_gaps && i > 0) gap = int'($urandom_range(0, 3));
      if (poke && i == 4) begin
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
      end
      send_byte(bytes[i], gap);
    end
`ifdef JTDSP16_PROG_CHKSUM_EN
    trailer = total;
    if (bad_ck) trailer = total ^ 16'($urandom_range(1, 65535));
    send_byte(trailer[7:0], 0);
    send_byte(trailer[15:8], 0);
`else
    trailer = '0;
`endif
    in_valid = 1'b0;

    got_done = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", got_done, 1);
    check("done_busy", o_busy, 0);
    check("done_err", o_err, exp_err);
    check("done_dsp_rst", o_dsp_rst, exp_err);
    check("done_ready", o_ready, 0);
    check("done_addr", o_addr, n - 1);

    check("wr_count", wq.size() - base_w, n);
    for (int i = 0; i < n && base_w + i < wq.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wq[base_w+i].addr, i);
      check($sformatf("wr_data%0d", i), wq[base_w+i].data, words[i]);
      if (no_gaps && i > 0)
        check($sformatf("wr_gap%0d", i), wq[base_w+i].cyc - wq[base_w+i-1].cyc, 3);
    end

    // Bytes offered in DONE are held off.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("done_hold_ready", o_ready, 0);
    end
    in_valid = 1'b0;
    check("done_once", done_rises - base_d, 1);
    check("no_extra_we", wq.size() - base_w, n);
    check("done_level", o_done, 1);
    tick();
  endtask

  logic [7:0] img[$];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      @(negedge clk);
      check("rst_ready", o_ready, 0);
      check("rst_addr", o_addr, 0);
      check("rst_data", o_data, 0);
      check("rst_we", o_we, 0);
      check("rst_dsp_rst", o_dsp_rst, 1);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
    end
    sel = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Fixed image, back-to-back bytes, whole 2^AW address space.
    img = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    run_load(1'b0, img, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for a high byte.
    sel   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h34, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dsp_rst", o_dsp_rst, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_we", o_we, 0);
    check("mid_rst_addr", o_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Same image with 5-cycle stalls before each high byte.
    run_load(1'b0, img, 5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start pulsed mid-load is ignored; reload from DONE with a new image.
    img = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    run_load(1'b0, img, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized loads on both instances.
    for (int r = 0; r < 10; r++) begin
      bit s;
      s = 1'($urandom);
      img.delete();
      for (int i = 0; i < 2 * (s ? LENB : LENA); i++) img.push_back(8'($urandom));
      run_load(s, img, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

`ifdef JTDSP16_PROG_CHKSUM_EN
    // Bad trailer then a good reload clears err and releases the DSP.
    img = '{8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(1'b0, img, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_load(1'b0, img, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtdsp16_prog_loader.md
Name: jtdsp16_prog_loader

Overview:
Feeds the DSP16 program ROM through its programming port (prog_addr/prog_data/prog_we).
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 16-bit words, and writes them to consecutive ROM addresses from 0.
- Holds the DSP core in reset (dsp_rst) until a complete image has been written.
- Sits between the system download path and the jtdsp16 top level.

Parameters:
AW, 12, ROM address width; matches prog_addr.
LEN, 4096, number of 16-bit words per image; legal range 1..2^AW.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load when in IDLE or DONE
in_data  input  8  download byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts in_data this cycle
prog_addr  output  AW  ROM write address
prog_data  output  16  ROM write data
prog_we  output  1  ROM write strobe, one cycle per word
dsp_rst  output  1  reset to the DSP core; high while not loaded
busy  output  1  a load is in progress
done  output  1  image complete, level
err  output  1  checksum mismatch, level (tied 0 without the optional feature)

Behaviour:
- Reset values: state=IDLE, in_ready=0, prog_addr=0, prog_data=0, prog_we=0, dsp_rst=1, busy=0, done=0, err=0.
- States: IDLE, LO, HI, WR, DONE (plus CKLO and CKHI with the optional feature).
- IDLE/DONE, start=1: go to LO. Clear prog_addr to 0, done to 0 and err to 0. Set dsp_rst=1 and busy=1.
- start while busy is ignored.
- in_ready is 1 exactly in LO, HI, CKLO and CKHI; it is decoded from the registered state only. A byte is accepted on a clock edge where in_valid & in_ready.
- LO, byte accepted: prog_data[7:0] <= in_data; go to HI.
- HI, byte accepted: prog_data[15:8] <= in_data; go to WR.
- WR: lasts one cycle. prog_we=1 with stable prog_addr and prog_data; in_ready=0.
- Leaving WR:
  - prog_addr != LEN-1: prog_addr increments, go to LO.
  - prog_addr == LEN-1: prog_addr is held, go to DONE (or to CKLO with the optional feature).
- Throughput is 3 cycles per word at minimum. in_valid gaps stall indefinitely in LO or HI with no timeout.
- prog_addr never wraps within a load. With LEN=2^AW the last write is to address 2^AW-1.
- DONE: busy=0, done=1. dsp_rst=0, unless err=1, in which case dsp_rst stays 1.
- Bytes offered in IDLE, WR or DONE are not accepted (in_ready=0); the upstream holds them.
- start and in_valid in the same cycle in IDLE: the transition to LO happens; the byte is not accepted until the next cycle.
- rst asserted mid-load: immediate return to reset values. Partial ROM contents are left as written.

Optional Feature:
Macro: JTDSP16_PROG_CHKSUM_EN
- Defined:
  - A running 16-bit sum (mod 2^16) of all written words is kept and cleared on start.
  - After the last WR, the loader accepts two extra bytes in CKLO (low) then CKHI (high), forming the expected checksum.
  - Mismatch sets err=1 on entry to DONE, and dsp_rst stays 1 until the next successful load.
  - Match gives err=0 and dsp_rst=0 in DONE.
- Not defined:
  - No checksum states and no sum register; err is constant 0.
  - The last WR goes directly to DONE.

Test Plan:
1. Reset mid-load: rst pulse while in HI -> next cycle dsp_rst=1, busy=0, done=0, in_ready=0, prog_we=0, prog_addr=0.
2. LEN=4, start, then bytes 34 12 78 56 BC 9A F0 DE with in_valid always 1 -> prog_we pulses at addr 0..3 with data 1234, 5678, 9ABC, DEF0. Pulses are 3 cycles apart. Then done=1 and dsp_rst=0.
3. Stalls: same image with in_valid dropped for 5 cycles between each low and high byte -> identical writes, no extra prog_we, in_ready stays 1 during gaps.
4. Start while busy: start pulsed after word 1 of a LEN=4 load -> ignored; prog_addr continues 2, 3; a single done.
5. Reload from DONE: start again with bytes 01 00 ... -> prog_addr restarts at 0, done drops, dsp_rst returns to 1 until the new image completes.
6. Checksum (JTDSP16_PROG_CHKSUM_EN, LEN=2): words 1234 and 0001, trailer 35 12 -> err=0, dsp_rst=0. Same words with trailer 00 00 -> err=1, dsp_rst=1, done=1.
